// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and fetch-stage state encoding.
// Imported by if_fetch_unit and if_fetch_perf.
package if_fetch_unit_pkg;

   localparam int          RegBus           = 32;
   localparam logic [31:0] ZeroWord         = 32'h0000_0000;
   localparam logic        Stop             = 1'b1;
   localparam logic        NoStop           = 1'b0;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

   localparam int IfStateBus = 3;

   typedef enum logic [IfStateBus-1:0] {
      IF_IDLE    = 3'd0,
      IF_REQ     = 3'd1,
      IF_WAIT    = 3'd2,
      IF_DONE    = 3'd3,
      IF_DISCARD = 3'd4
   } if_state_e;

endpackage

// File: rtl/if_fetch_perf.sv
// Saturating fetch-stage event counters (fetches, stall cycles, discards).
// Ports: clk, rst (async low), three event strobes in, three counters out.
module if_fetch_perf
   import if_fetch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_inc,
   input  logic        wait_inc,
   input  logic        discard_inc,
   output logic [31:0] fetch_cnt,
   output logic [31:0] wait_cnt,
   output logic [15:0] discard_cnt
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_cnt   <= ZeroWord;
         wait_cnt    <= ZeroWord;
         discard_cnt <= '0;
      end else begin
         if (fetch_inc && fetch_cnt != '1)
            fetch_cnt <= fetch_cnt + 32'd1;
         if (wait_inc && wait_cnt != '1)
            wait_cnt <= wait_cnt + 32'd1;
         if (discard_inc && discard_cnt != '1)
            discard_cnt <= discard_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage bus master: owns the PC, fetches one word at a time over an
// SRAM-like port and drops fetches killed by a flush.
// Ports: clk, rst (async low), stall/flush/new_pc from controller,
// inst_* bus port, pc_o/inst_o/inst_valid_o to IF/ID, stallreq_from_if.
// Optional IF_FETCH_PERF_EN adds perf_fetch_cnt/perf_wait_cnt/perf_discard_cnt.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] new_pc,
   output logic              inst_req,
   output logic              inst_wr,
   output logic [1:0]        inst_size,
   output logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_addr_ok,
   input  logic              inst_data_ok,
   input  logic [DATA_W-1:0] inst_rdata,
   output logic [ADDR_W-1:0] pc_o,
   output logic [DATA_W-1:0] inst_o,
   output logic              inst_valid_o,
   output logic              stallreq_from_if
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_wait_cnt,
   output logic [15:0]       perf_discard_cnt
`endif
);

   if_state_e         state, state_n;
   logic [ADDR_W-1:0] pc, pc_n;
   logic [ADDR_W-1:0] pco_n;
   logic [DATA_W-1:0] inst_n;
   logic              valid_n;
   logic              rpend, rpend_n;
   logic [ADDR_W-1:0] rpc, rpc_n;
   logic              deliver;

   // Upper stall bits belong to later stages.
   logic unused_stall;
   assign unused_stall = ^stall[5:2];

   assign inst_wr   = 1'b0;
   assign inst_size = 2'b10;
   assign inst_addr = pc;
   assign inst_req  = (state == IF_REQ);

   assign deliver = (state == IF_WAIT) && inst_data_ok
                  && !flush && !rpend;

   // Released in the data_ok cycle so the controller can advance
   // on the same edge that captures the instruction.
   always_comb begin
      stallreq_from_if = NoStop;
      unique case (state)
         IF_REQ, IF_DISCARD: stallreq_from_if = Stop;
         IF_WAIT:            stallreq_from_if = deliver ? NoStop : Stop;
         default:            stallreq_from_if = NoStop;
      endcase
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      pco_n   = pc_o;
      inst_n  = inst_o;
      valid_n = inst_valid_o;
      rpend_n = rpend;
      rpc_n   = rpc;
      unique case (state)
         IF_IDLE: begin
            if (flush)
               pc_n = new_pc;
            else if (!stall[0])
               state_n = IF_REQ;
         end
         IF_REQ: begin
            // Address must stay put until accepted; park the redirect.
            if (flush) begin
               rpend_n = 1'b1;
               rpc_n   = new_pc;
            end
            if (inst_addr_ok)
               state_n = (flush || rpend) ? IF_DISCARD : IF_WAIT;
         end
         IF_WAIT: begin
            if (inst_data_ok) begin
               if (flush) begin
                  pc_n    = new_pc;
                  rpend_n = 1'b0;
                  state_n = IF_REQ;
               end else if (rpend) begin
                  pc_n    = rpc;
                  rpend_n = 1'b0;
                  state_n = IF_REQ;
               end else begin
                  inst_n  = inst_rdata;
                  pco_n   = pc;
                  valid_n = 1'b1;
                  state_n = IF_DONE;
               end
            end else if (flush) begin
               // Data still owed by the slave; drop it when it comes.
               pc_n    = new_pc;
               rpend_n = 1'b1;
               rpc_n   = new_pc;
               state_n = IF_DISCARD;
            end
         end
         IF_DONE: begin
            if (flush) begin
               pc_n    = new_pc;
               state_n = IF_REQ;
            end else if (!stall[1]) begin
               pc_n    = pc + ADDR_W'(4);
               valid_n = 1'b0;
               state_n = IF_REQ;
            end
         end
         IF_DISCARD: begin
            if (flush)
               rpc_n = new_pc;
            if (inst_data_ok) begin
               pc_n    = flush ? new_pc : rpc;
               rpend_n = 1'b0;
               state_n = IF_REQ;
            end
         end
         default: state_n = IF_IDLE;
      endcase
      if (flush)
         valid_n = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IF_IDLE;
         pc           <= RESET_PC;
         pc_o         <= '0;
         inst_o       <= '0;
         inst_valid_o <= 1'b0;
         rpend        <= 1'b0;
         rpc          <= '0;
      end else begin
         state        <= state_n;
         pc           <= pc_n;
         pc_o         <= pco_n;
         inst_o       <= inst_n;
         inst_valid_o <= valid_n;
         rpend        <= rpend_n;
         rpc          <= rpc_n;
      end
   end

`ifdef IF_FETCH_PERF_EN
   if_fetch_perf u_perf (
      .clk         (clk),
      .rst         (rst),
      .fetch_inc   (deliver),
      .wait_inc    (stallreq_from_if),
      .discard_inc ((state_n == IF_DISCARD) && (state != IF_DISCARD)),
      .fetch_cnt   (perf_fetch_cnt),
      .wait_cnt    (perf_wait_cnt),
      .discard_cnt (perf_discard_cnt)
   );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-programmable slave.
// Slave returns 0x24010001 at BFC00000, otherwise the inverted address.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        inst_req, inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic        addr_ok, data_ok;
   logic [31:0] rdata;
   logic [31:0] pc_o, inst_o;
   logic        valid, sreq;

   int checks   = 0;
   int failures = 0;

   int addr_lat = 0;
   int data_lat = 0;
   int acnt, dcnt;
   logic        pend;
   logic [31:0] cap;

   always #5 clk = ~clk;

   if_fetch_unit dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .flush            (flush),
      .new_pc           (new_pc),
      .inst_req         (inst_req),
      .inst_wr          (inst_wr),
      .inst_size        (inst_size),
      .inst_addr        (inst_addr),
      .inst_addr_ok     (addr_ok),
      .inst_data_ok     (data_ok),
      .inst_rdata       (rdata),
      .pc_o             (pc_o),
      .inst_o           (inst_o),
      .inst_valid_o     (valid),
      .stallreq_from_if (sreq)
   );

   assign addr_ok = inst_req && (acnt >= addr_lat);
   assign data_ok = pend && (dcnt >= data_lat);
   assign rdata   = !pend ? 32'hDEADBEEF :
                    (cap == 32'hBFC00000) ? 32'h24010001 : ~cap;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         acnt <= 0; dcnt <= 0; pend <= 1'b0; cap <= 32'h0;
      end else begin
         if (inst_req && !addr_ok) acnt <= acnt + 1;
         if (addr_ok) begin
            acnt <= 0; dcnt <= 0; pend <= 1'b1; cap <= inst_addr;
         end else if (pend && data_ok) pend <= 1'b0;
         else if (pend) dcnt <= dcnt + 1;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; stall = 6'b0; flush = 1'b0; new_pc = 32'h0;
      tick(); tick();
      checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL rst_req got %b want 0", inst_req); end
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b want 0", valid); end
      checks++; if (inst_o !== 32'h0) begin failures++; $display("FAIL rst_inst got %h want 0", inst_o); end
      checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL rst_pco got %h want 0", pc_o); end
      checks++; if (sreq !== 1'b0) begin failures++; $display("FAIL rst_sreq got %b want 0", sreq); end
      checks++; if (inst_addr !== 32'hBFC00000) begin failures++; $display("FAIL rst_addr got %h want bfc00000", inst_addr); end
      checks++; if ({inst_wr, inst_size} !== 3'b010) begin failures++; $display("FAIL rst_wrsize got %b want 010", {inst_wr, inst_size}); end
   endtask

   task automatic test_first_fetch();
      rst = 1'b1;
      tick();
      checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00000) begin failures++; $display("FAIL ff_req got %b/%h want 1/bfc00000", inst_req, inst_addr); end
      checks++; if (sreq !== 1'b1) begin failures++; $display("FAIL ff_sreq_req got %b want 1", sreq); end
      tick();
      checks++; if (sreq !== 1'b0) begin failures++; $display("FAIL ff_sreq_release got %b want 0", sreq); end
      tick();
      checks++; if (valid !== 1'b1 || inst_o !== 32'h24010001 || pc_o !== 32'hBFC00000) begin failures++; $display("FAIL ff_deliver got %b/%h/%h want 1/24010001/bfc00000", valid, inst_o, pc_o); end
      tick();
      checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00004) begin failures++; $display("FAIL ff_next got %b/%h want 1/bfc00004", inst_req, inst_addr); end
   endtask

   task automatic test_data_delay();
      int n = 0;
      bit done = 0;
      data_lat = 5;
      for (int i = 0; i < 20 && !done; i++) begin
         if (sreq) n++;
         if (valid) done = 1;
         else begin
            checks++; if (inst_o !== 32'h24010001) begin failures++; $display("FAIL dly_hold got %h want 24010001", inst_o); end
            tick();
         end
      end
      checks++; if (!done) begin failures++; $display("FAIL dly_timeout got no valid want valid"); end
      checks++; if (n != 6) begin failures++; $display("FAIL dly_sreq_cycles got %0d want 6", n); end
      checks++; if (inst_o !== 32'h403FFFFB || pc_o !== 32'hBFC00004) begin failures++; $display("FAIL dly_deliver got %h/%h want 403ffffb/bfc00004", inst_o, pc_o); end
      data_lat = 0;
   endtask

   task automatic test_stall_done();
      stall = 6'b000111;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (inst_req !== 1'b0 || valid !== 1'b1 || inst_o !== 32'h403FFFFB || pc_o !== 32'hBFC00004) begin failures++; $display("FAIL stall_hold%0d got %b/%b/%h/%h want 0/1/403ffffb/bfc00004", i, inst_req, valid, inst_o, pc_o); end
      end
      stall = 6'b0;
      tick();
      checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00008) begin failures++; $display("FAIL stall_resume got %b/%h want 1/bfc00008", inst_req, inst_addr); end
      tick(); tick();
      checks++; if (inst_o !== 32'h403FFFF7 || pc_o !== 32'hBFC00008) begin failures++; $display("FAIL stall_next got %h/%h want 403ffff7/bfc00008", inst_o, pc_o); end
   endtask

   task automatic test_flush_wait();
      bit seen = 0;
      tick();
      data_lat = 3;
      tick();
      flush = 1'b1; new_pc = 32'hBFC00380;
      tick();
      flush = 1'b0;
      checks++; if (inst_req !== 1'b0 || sreq !== 1'b1 || valid !== 1'b0) begin failures++; $display("FAIL fw_discard got %b/%b/%b want 0/1/0", inst_req, sreq, valid); end
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         if (inst_req) seen = 1;
      end
      checks++; if (!seen || inst_addr !== 32'hBFC00380) begin failures++; $display("FAIL fw_refetch got %b/%h want 1/bfc00380", seen, inst_addr); end
      checks++; if (inst_o !== 32'h403FFFF7) begin failures++; $display("FAIL fw_dropped got %h want 403ffff7", inst_o); end
      data_lat = 0;
      tick(); tick();
      checks++; if (valid !== 1'b1 || inst_o !== 32'h403FFC7F || pc_o !== 32'hBFC00380) begin failures++; $display("FAIL fw_deliver got %b/%h/%h want 1/403ffc7f/bfc00380", valid, inst_o, pc_o); end
   endtask

   task automatic test_flush_done();
      flush = 1'b1; new_pc = 32'hBFC00100;
      tick();
      flush = 1'b0;
      checks++; if (valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hBFC00100) begin failures++; $display("FAIL fd got %b/%b/%h want 0/1/bfc00100", valid, inst_req, inst_addr); end
   endtask

   task automatic test_flush_req();
      addr_lat = 3;
      flush = 1'b1; new_pc = 32'hBFC00200;
      for (int i = 0; i < 3; i++) begin
         tick();
         flush = 1'b0;
         checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00100) begin failures++; $display("FAIL fr_hold%0d got %b/%h want 1/bfc00100", i, inst_req, inst_addr); end
      end
      addr_lat = 0;
      tick();
      checks++; if (inst_req !== 1'b0 || sreq !== 1'b1) begin failures++; $display("FAIL fr_discard got %b/%b want 0/1", inst_req, sreq); end
      tick();
      checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00200) begin failures++; $display("FAIL fr_refetch got %b/%h want 1/bfc00200", inst_req, inst_addr); end
      tick(); tick();
      checks++; if (valid !== 1'b1 || inst_o !== 32'h403FFDFF || pc_o !== 32'hBFC00200) begin failures++; $display("FAIL fr_deliver got %b/%h/%h want 1/403ffdff/bfc00200", valid, inst_o, pc_o); end
   endtask

   task automatic test_wrap();
      flush = 1'b1; new_pc = 32'hFFFFFFFC;
      tick();
      flush = 1'b0;
      tick(); tick();
      checks++; if (inst_o !== 32'h00000003 || pc_o !== 32'hFFFFFFFC) begin failures++; $display("FAIL wrap_deliver got %h/%h want 00000003/fffffffc", inst_o, pc_o); end
      tick();
      checks++; if (inst_req !== 1'b1 || inst_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr got %b/%h want 1/00000000", inst_req, inst_addr); end
   endtask

   task automatic test_reset_mid();
      data_lat = 5;
      tick();
      rst = 1'b0;
      #1;
      checks++; if (inst_req !== 1'b0 || sreq !== 1'b0 || valid !== 1'b0) begin failures++; $display("FAIL rm_ctrl got %b/%b/%b want 0/0/0", inst_req, sreq, valid); end
      checks++; if (inst_o !== 32'h0 || pc_o !== 32'h0 || inst_addr !== 32'hBFC00000) begin failures++; $display("FAIL rm_data got %h/%h/%h want 0/0/bfc00000", inst_o, pc_o, inst_addr); end
      data_lat = 0;
      tick();
      rst = 1'b1;
      tick();
      checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00000) begin failures++; $display("FAIL rm_refetch got %b/%h want 1/bfc00000", inst_req, inst_addr); end
      tick(); tick();
      checks++; if (valid !== 1'b1 || inst_o !== 32'h24010001) begin failures++; $display("FAIL rm_deliver got %b/%h want 1/24010001", valid, inst_o); end
   endtask

   task automatic test_idle_flush();
      rst = 1'b0; stall = 6'b000001;
      tick();
      rst = 1'b1;
      tick(); tick();
      checks++; if (inst_req !== 1'b0 || inst_addr !== 32'hBFC00000) begin failures++; $display("FAIL idle_hold got %b/%h want 0/bfc00000", inst_req, inst_addr); end
      flush = 1'b1; new_pc = 32'hBFC00500;
      tick();
      flush = 1'b0;
      checks++; if (inst_req !== 1'b0 || inst_addr !== 32'hBFC00500) begin failures++; $display("FAIL idle_flush got %b/%h want 0/bfc00500", inst_req, inst_addr); end
      stall = 6'b0;
      tick();
      checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00500) begin failures++; $display("FAIL idle_go got %b/%h want 1/bfc00500", inst_req, inst_addr); end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_data_delay();
      test_stall_done();
      test_flush_wait();
      test_flush_done();
      test_flush_req();
      test_wrap();
      test_reset_mid();
      test_idle_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
